// File: rtl/uart_tx_queue_pkg.sv
// Shared definitions for the UART transmit queue.
//   - UART register offsets and status bit positions as seen on the UART bus.
//   - Encoding of the drain FSM states.
//   - Helper that extracts the TX-busy flag from a status byte.
package uart_tx_queue_pkg;

  localparam logic [4:0] UART_REG_DATA   = 5'd0;
  localparam logic [4:0] UART_REG_STATUS = 5'd4;

  localparam int STAT_TX_BUSY  = 0;
  localparam int STAT_RX_AVAIL = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_POLL  = 2'd1,
    ST_SEND  = 2'd2,
    ST_GUARD = 2'd3
  } tx_state_e;

  function automatic logic stat_tx_busy(input logic [7:0] status);
    return status[STAT_TX_BUSY];
  endfunction

endpackage

// File: rtl/uart_tx_queue_sync_fifo.sv
// sync_fifo: single-clock circular-buffer FIFO.
//   clk_i, rst_i    clock, asynchronous active-high reset
//   push_i, data_i  write request and data; ignored while full
//   pop_i           read request; ignored while empty
//   head_o          oldest entry, read from registered storage
//   full_o, empty_o status, combinational from registered pointers
//   level_o         number of stored entries (0..DEPTH)
// Pointers carry one extra wrap bit so full and empty can be told apart
// without a separate counter.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer difference modulo 2*DEPTH is the fill level directly.
  assign level_o = wptr_q - rptr_q;
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: buffered transmit front-end for the memory-mapped UART.
//   clk, rst                       clock, asynchronous active-high reset
//   push_valid/push_data/push_ready producer byte port (valid/ready)
//   level, empty                   queue occupancy
//   u_addr, u_ren, u_wen, u_wdata  UART bus master side (registered)
//   u_rdata, u_rd_valid            UART read response
// Bytes are queued, then drained one at a time: poll the status register
// until TX is idle, write the head byte, and wait GUARD cycles so the
// UART's own busy flag has time to rise before the next poll.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | nothing in flight; issue a status read when queue non-empty
//   ST_POLL  | status read issued; wait for read data
//   ST_SEND  | data write on the bus; head byte popped this cycle
//   ST_GUARD | hold-off after a write until the UART reports busy
module uart_tx_queue
  import uart_tx_queue_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int GUARD = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_valid,
  input  logic [7:0]  push_data,
  output logic        push_ready,
  output logic [AW:0] level,
  output logic        empty,
  output logic [4:0]  u_addr,
  output logic        u_ren,
  input  logic [7:0]  u_rdata,
  input  logic        u_rd_valid,
  output logic        u_wen,
  output logic [7:0]  u_wdata
);

  localparam int GW = $clog2(GUARD + 1);
  localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD - 1);

  tx_state_e     state_q, state_d;
  logic [GW-1:0] guard_q, guard_d;
  logic [4:0]    addr_q, addr_d;
  logic          ren_q, ren_d;
  logic          wen_q, wen_d;
  logic [7:0]    wdata_q, wdata_d;

  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic [7:0]    fifo_head;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8),
    .AW    (AW)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push_valid),
    .data_i  (push_data),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  assign push_ready = !fifo_full;
  assign empty      = fifo_empty;

  // Bus outputs are registered: each strobe is set on the transition into
  // the state it belongs to, so it is high for exactly one cycle and the
  // address/data stay put between strobes.
  always_comb begin
    state_d  = state_q;
    guard_d  = guard_q;
    addr_d   = addr_q;
    ren_d    = 1'b0;
    wen_d    = 1'b0;
    wdata_d  = wdata_q;
    fifo_pop = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          ren_d   = 1'b1;
          addr_d  = UART_REG_STATUS;
          state_d = ST_POLL;
        end
      end
      ST_POLL: begin
        if (u_rd_valid) begin
          if (stat_tx_busy(u_rdata)) begin
            state_d = ST_IDLE;
          end else begin
            wen_d   = 1'b1;
            addr_d  = UART_REG_DATA;
            wdata_d = fifo_head;
            state_d = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        // Head is non-empty here: only this FSM pops and it polled first.
        fifo_pop = 1'b1;
        guard_d  = GUARD_LOAD;
        state_d  = ST_GUARD;
      end
      ST_GUARD: begin
        if (guard_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          guard_d = guard_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      guard_q <= '0;
      addr_q  <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      guard_q <= guard_d;
      addr_q  <= addr_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
    end
  end

  assign u_addr  = addr_q;
  assign u_ren   = ren_q;
  assign u_wen   = wen_q;
  assign u_wdata = wdata_q;

endmodule
